// File: rtl/csr_pkg.sv
// Shared CSR addresses, mstatus/interrupt bit positions and address classification
// helpers for the machine-mode CSR file.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    localparam int unsigned IRQ_MSI = 3;
    localparam int unsigned IRQ_MTI = 7;
    localparam int unsigned IRQ_MEI = 11;

    localparam logic [31:0] MISA_DEFAULT  = 32'h4000_0100;
    localparam logic [31:0] MIE_WARL_MASK = 32'h0000_0888;

    function automatic logic csr_is_implemented(input logic [11:0] addr);
        logic hit;
        hit = 1'b0;
        case (addr)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC,
            CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP,
            CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH,
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic csr_is_read_only(input logic [11:0] addr);
        return (addr == CSR_MVENDORID) || (addr == CSR_MARCHID) ||
               (addr == CSR_MIMPID)    || (addr == CSR_MHARTID);
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently loadable 32-bit halves.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wen_lo,
    input  logic        wen_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] value_q;
    logic [63:0] value_d;
    logic [63:0] value_inc;

    // The half not being written still takes the increment, carry included.
    always_comb begin
        value_inc = value_q + 64'(inc);
        value_d   = value_inc;
        if (wen_lo) begin
            value_d[31:0] = wdata;
        end
        if (wen_hi) begin
            value_d[63:32] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/machine_csr_file.sv
// Machine-mode CSR file: combinational read port, registered writes, trap state,
// interrupt request generation and mcycle/minstret counters.
module machine_csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID         = 32'd0,
    parameter logic [31:0] MISA_VALUE      = MISA_DEFAULT,
    parameter logic [31:0] RESET_MTVEC     = 32'h0000_0000,
    parameter bit          ENABLE_COUNTERS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_ren,
    input  logic        csr_wen,
    input  logic [11:0] csr_rwaddr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic [31:0] csr_mepc,
    input  logic        exception_returned,
    input  logic        trap_en,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_soft,
    input  logic        instret_pulse,
    output logic        interrupt_req,
    output logic        interrupt_pending,
    output logic [31:0] trap_vector,
    output logic        illegal_csr
);

    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q,      mie_d;
    logic [31:0] mip_q,      mip_d;
    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;
    logic [31:0] mtval_q,    mtval_d;

    logic        csr_commit;
    logic        cnt_commit;
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic [31:0] vec_base;

    // A CSR write only lands when neither a trap nor an MRET claims the cycle.
    assign csr_commit = csr_wen && !trap_en && !exception_returned;
    assign cnt_commit = csr_commit && ENABLE_COUNTERS;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;

        mip_d          = '0;
        mip_d[IRQ_MEI] = irq_ext;
        mip_d[IRQ_MTI] = irq_timer;
        mip_d[IRQ_MSI] = irq_soft;

        if (trap_en) begin
            mepc_d         = {trap_pc[31:2], 2'b00};
            mcause_d       = trap_cause;
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (exception_returned) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_wen) begin
            case (csr_rwaddr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = csr_wdata[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_d      = csr_wdata & MIE_WARL_MASK;
                CSR_MTVEC:    mtvec_d    = {csr_wdata[31:2], 1'b0, csr_wdata[0]};
                CSR_MSCRATCH: mscratch_d = csr_wdata;
                CSR_MEPC:     mepc_d     = {csr_wdata[31:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = csr_wdata;
                CSR_MTVAL:    mtval_d    = csr_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= {RESET_MTVEC[31:2], 1'b0, RESET_MTVEC[0]};
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= mip_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (ENABLE_COUNTERS),
        .wen_lo (cnt_commit && (csr_rwaddr == CSR_MCYCLE)),
        .wen_hi (cnt_commit && (csr_rwaddr == CSR_MCYCLEH)),
        .wdata  (csr_wdata),
        .value  (mcycle)
    );

    csr_counter64 u_minstret (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (ENABLE_COUNTERS && instret_pulse),
        .wen_lo (cnt_commit && (csr_rwaddr == CSR_MINSTRET)),
        .wen_hi (cnt_commit && (csr_rwaddr == CSR_MINSTRETH)),
        .wdata  (csr_wdata),
        .value  (minstret)
    );

    always_comb begin
        csr_rdata = '0;
        case (csr_rwaddr)
            CSR_MSTATUS: begin
                csr_rdata[12:11]            = 2'b11;
                csr_rdata[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
                csr_rdata[MSTATUS_MIE_BIT]  = mstatus_mie_q;
            end
            CSR_MISA:      csr_rdata = MISA_VALUE;
            CSR_MIE:       csr_rdata = mie_q;
            CSR_MTVEC:     csr_rdata = mtvec_q;
            CSR_MSCRATCH:  csr_rdata = mscratch_q;
            CSR_MEPC:      csr_rdata = mepc_q;
            CSR_MCAUSE:    csr_rdata = mcause_q;
            CSR_MTVAL:     csr_rdata = mtval_q;
            CSR_MIP:       csr_rdata = mip_q;
            CSR_MCYCLE:    csr_rdata = ENABLE_COUNTERS ? mcycle[31:0]    : '0;
            CSR_MCYCLEH:   csr_rdata = ENABLE_COUNTERS ? mcycle[63:32]   : '0;
            CSR_MINSTRET:  csr_rdata = ENABLE_COUNTERS ? minstret[31:0]  : '0;
            CSR_MINSTRETH: csr_rdata = ENABLE_COUNTERS ? minstret[63:32] : '0;
            CSR_MHARTID:   csr_rdata = HART_ID;
            default:       csr_rdata = '0;
        endcase
    end

    assign illegal_csr = ((csr_ren || csr_wen) && !csr_is_implemented(csr_rwaddr)) ||
                         (csr_wen && csr_is_read_only(csr_rwaddr));

    assign interrupt_pending = |(mip_q & mie_q);
    assign interrupt_req     = mstatus_mie_q && interrupt_pending;
    assign csr_mepc          = mepc_q;

    // Vectored mode only offsets for interrupts; the shifted cause wraps mod 2^32.
    assign vec_base    = {mtvec_q[31:2], 2'b00};
    assign trap_vector = (mtvec_q[0] && trap_cause[31]) ?
                         vec_base + {trap_cause[29:0], 2'b00} : vec_base;

endmodule

// File: tb/tb_machine_csr_file.sv
// Randomised and directed bench for machine_csr_file against a behavioural CSR model.
module tb_machine_csr_file;

    localparam logic [31:0] TB_HART  = 32'h0000_0003;
    localparam logic [31:0] TB_MISA  = 32'h4000_0100;
    localparam logic [31:0] TB_MTVEC = 32'h0000_0204;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_ren, csr_wen;
    logic [11:0] csr_rwaddr;
    logic [31:0] csr_wdata, csr_rdata, csr_mepc;
    logic        exception_returned, trap_en;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic        irq_ext, irq_timer, irq_soft, instret_pulse;
    logic        interrupt_req, interrupt_pending, illegal_csr;
    logic [31:0] trap_vector;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit          m_mie, m_mpie;
    logic [31:0] m_ie, m_ip, m_tvec, m_scratch, m_epc, m_cause, m_tval;
    logic [63:0] m_cyc, m_ins;

    always #5 clk = ~clk;

    machine_csr_file #(
        .HART_ID        (TB_HART),
        .MISA_VALUE     (TB_MISA),
        .RESET_MTVEC    (TB_MTVEC),
        .ENABLE_COUNTERS(1'b1)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .csr_ren           (csr_ren),
        .csr_wen           (csr_wen),
        .csr_rwaddr        (csr_rwaddr),
        .csr_wdata         (csr_wdata),
        .csr_rdata         (csr_rdata),
        .csr_mepc          (csr_mepc),
        .exception_returned(exception_returned),
        .trap_en           (trap_en),
        .trap_cause        (trap_cause),
        .trap_pc           (trap_pc),
        .trap_tval         (trap_tval),
        .irq_ext           (irq_ext),
        .irq_timer         (irq_timer),
        .irq_soft          (irq_soft),
        .instret_pulse     (instret_pulse),
        .interrupt_req     (interrupt_req),
        .interrupt_pending (interrupt_pending),
        .trap_vector       (trap_vector),
        .illegal_csr       (illegal_csr)
    );

    function automatic logic [31:0] exp_rdata(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301: return TB_MISA;
            12'h304: return m_ie;
            12'h305: return m_tvec;
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return m_ip;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            12'hF14: return TB_HART;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit exp_illegal(input bit ren, input bit wen, input logic [11:0] a);
        bit impl, ro;
        ro   = (a >= 12'hF11) && (a <= 12'hF14);
        impl = ro || (a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82});
        return ((ren || wen) && !impl) || (wen && ro);
    endfunction

    function automatic logic [31:0] exp_vector(input logic [31:0] cause);
        logic [31:0] base;
        base = m_tvec & 32'hFFFF_FFFC;
        if (m_tvec[0] && cause[31]) return base + 32'(4 * {1'b0, cause[30:0]});
        return base;
    endfunction

    // Advance the model by one clock using the inputs currently applied, then clock the DUT.
    task automatic step();
        logic [63:0] nc, ni;
        logic [31:0] nip;
        if (!rst_n) begin
            m_mie = 0; m_mpie = 0; m_ie = 0; m_ip = 0; m_tvec = TB_MTVEC & 32'hFFFF_FFFD;
            m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0; m_cyc = 0; m_ins = 0;
        end else begin
            nc  = m_cyc + 64'd1;
            ni  = m_ins + (instret_pulse ? 64'd1 : 64'd0);
            nip = (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0) | (irq_soft ? 32'h8 : 32'h0);
            if (trap_en) begin
                m_epc = trap_pc & 32'hFFFF_FFFC; m_cause = trap_cause; m_tval = trap_tval;
                m_mpie = m_mie; m_mie = 0;
            end else if (exception_returned) begin
                m_mie = m_mpie; m_mpie = 1;
            end else if (csr_wen) begin
                case (csr_rwaddr)
                    12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                    12'h304: m_ie      = csr_wdata & 32'h888;
                    12'h305: m_tvec    = csr_wdata & 32'hFFFF_FFFD;
                    12'h340: m_scratch = csr_wdata;
                    12'h341: m_epc     = csr_wdata & 32'hFFFF_FFFC;
                    12'h342: m_cause   = csr_wdata;
                    12'h343: m_tval    = csr_wdata;
                    12'hB00: nc = {nc[63:32], csr_wdata};
                    12'hB80: nc = {csr_wdata, nc[31:0]};
                    12'hB02: ni = {ni[63:32], csr_wdata};
                    12'hB82: ni = {csr_wdata, ni[31:0]};
                    default: ;
                endcase
            end
            m_cyc = nc; m_ins = ni; m_ip = nip;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csr_ren = 0; csr_wen = 0; exception_returned = 0; trap_en = 0; instret_pulse = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_wen = 1; csr_rwaddr = a; csr_wdata = d;
        step();
        csr_wen = 0;
    endtask

    task automatic peek(input logic [11:0] a, output logic [31:0] d);
        csr_rwaddr = a; csr_ren = 1; #1; d = csr_rdata; csr_ren = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 0; idle(); irq_ext = 0; irq_timer = 0; irq_soft = 0;
        csr_rwaddr = 0; csr_wdata = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
        step(); step();
        peek(12'h300, d);
        n_checks++; if (d !== 32'h0000_1800) begin n_fail++; $display("FAIL reset_mstatus got %h exp %h", d, 32'h1800); end
        peek(12'h305, d);
        n_checks++; if (d !== TB_MTVEC) begin n_fail++; $display("FAIL reset_mtvec got %h exp %h", d, TB_MTVEC); end
        peek(12'hB00, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mcycle got %h exp 0", d); end
        n_checks++;
        if (interrupt_req !== 1'b0 || interrupt_pending !== 1'b0 || csr_mepc !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs req=%b pend=%b mepc=%h exp 0/0/0", interrupt_req, interrupt_pending, csr_mepc);
        end
        rst_n = 1;
        step();
        peek(12'hB00, d);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL mcycle_after_reset got %h exp 1", d); end
    endtask

    task automatic test_scratch_and_readonly();
        logic [31:0] d;
        wr(12'h340, 32'hDEAD_BEEF);
        peek(12'h340, d);
        n_checks++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mscratch_rw got %h exp DEADBEEF", d); end
        csr_wen = 1; csr_rwaddr = 12'hF14; csr_wdata = 32'h1234_5678; #1;
        n_checks++; if (illegal_csr !== 1'b1) begin n_fail++; $display("FAIL hartid_write_illegal got %b exp 1", illegal_csr); end
        step(); csr_wen = 0;
        peek(12'hF14, d);
        n_checks++; if (d !== TB_HART) begin n_fail++; $display("FAIL hartid_unchanged got %h exp %h", d, TB_HART); end
        csr_ren = 1; csr_rwaddr = 12'h7C0; #1;
        n_checks++;
        if (illegal_csr !== 1'b1 || csr_rdata !== 32'h0) begin
            n_fail++; $display("FAIL unimpl_read ill=%b data=%h exp 1/0", illegal_csr, csr_rdata);
        end
        csr_ren = 0; csr_wen = 1; csr_rwaddr = 12'h344; csr_wdata = 32'hFFFF_FFFF; #1;
        n_checks++; if (illegal_csr !== 1'b0) begin n_fail++; $display("FAIL mip_write_legal got %b exp 0", illegal_csr); end
        step(); csr_wen = 0;
        peek(12'h344, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mip_write_ignored got %h exp 0", d); end
    endtask

    task automatic test_interrupts();
        wr(12'h304, 32'h0000_0800);
        wr(12'h300, 32'h0000_0008);
        irq_ext = 1; #1;
        n_checks++; if (interrupt_req !== 1'b0) begin n_fail++; $display("FAIL irq_same_cycle got %b exp 0", interrupt_req); end
        step();
        n_checks++;
        if (interrupt_req !== 1'b1 || interrupt_pending !== 1'b1) begin
            n_fail++; $display("FAIL irq_next_cycle req=%b pend=%b exp 1/1", interrupt_req, interrupt_pending);
        end
        wr(12'h300, 32'h0);
        n_checks++;
        if (interrupt_req !== 1'b0 || interrupt_pending !== 1'b1) begin
            n_fail++; $display("FAIL irq_mie_off req=%b pend=%b exp 0/1", interrupt_req, interrupt_pending);
        end
        irq_ext = 0; irq_timer = 1; step();
        n_checks++; if (interrupt_pending !== 1'b0) begin n_fail++; $display("FAIL irq_masked_timer pend=%b exp 0", interrupt_pending); end
        irq_timer = 0; step();
    endtask

    task automatic test_trap_vector();
        logic [31:0] d;
        wr(12'h305, 32'h1000_0001);
        wr(12'h300, 32'h0000_0008);
        trap_en = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h24; trap_tval = 32'h55; #1;
        n_checks++; if (trap_vector !== 32'h1000_001C) begin n_fail++; $display("FAIL vec_interrupt got %h exp 1000001C", trap_vector); end
        step(); trap_en = 0;
        peek(12'h341, d);
        n_checks++; if (d !== 32'h24 || csr_mepc !== 32'h24) begin n_fail++; $display("FAIL trap_mepc got %h/%h exp 24", d, csr_mepc); end
        peek(12'h300, d);
        n_checks++; if (d !== 32'h1880) begin n_fail++; $display("FAIL trap_mstatus got %h exp 1880", d); end
        trap_cause = 32'h0000_0002; #1;
        n_checks++; if (trap_vector !== 32'h1000_0000) begin n_fail++; $display("FAIL vec_exception got %h exp 10000000", trap_vector); end
    endtask

    task automatic test_precedence();
        logic [31:0] d;
        wr(12'h300, 32'h0000_0008);
        trap_en = 1; trap_pc = 32'h40; trap_cause = 32'h2;
        csr_wen = 1; csr_rwaddr = 12'h341; csr_wdata = 32'h80;
        step(); idle();
        peek(12'h341, d);
        n_checks++; if (d !== 32'h40) begin n_fail++; $display("FAIL trap_over_write got %h exp 40", d); end
        exception_returned = 1; csr_wen = 1; csr_rwaddr = 12'h300; csr_wdata = 32'h0;
        step(); idle();
        peek(12'h300, d);
        n_checks++; if (d !== 32'h1888) begin n_fail++; $display("FAIL mret_mstatus got %h exp 1888", d); end
        n_checks++; if (csr_mepc !== 32'h40) begin n_fail++; $display("FAIL mret_mepc got %h exp 40", csr_mepc); end
    endtask

    task automatic test_counters();
        logic [31:0] d;
        wr(12'hB80, 32'h0);
        wr(12'hB00, 32'hFFFF_FFFF);
        peek(12'hB00, d);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mcycle_load got %h exp FFFFFFFF", d); end
        step();
        peek(12'hB00, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap_lo got %h exp 0", d); end
        peek(12'hB80, d);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL mcycle_carry_hi got %h exp 1", d); end
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'h5);
        peek(12'hB80, d);
        n_checks++; if (d !== 32'h5) begin n_fail++; $display("FAIL mcycleh_write_wins got %h exp 5", d); end
        peek(12'hB00, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mcycle_lo_wrapped got %h exp 0", d); end
        wr(12'hB82, 32'hFFFF_FFFF);
        wr(12'hB02, 32'hFFFF_FFFF);
        instret_pulse = 1; step(); instret_pulse = 0;
        peek(12'hB02, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL minstret_wrap_lo got %h exp 0", d); end
        peek(12'hB82, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL minstret_wrap_hi got %h exp 0", d); end
    endtask

    task automatic test_random();
        logic [11:0] addrs [21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11,
                                    12'hF12, 12'hF13, 12'hF14, 12'h000, 12'h7C0, 12'hB01, 12'h306};
        for (int i = 0; i < 400; i++) begin
            csr_rwaddr = addrs[$urandom_range(0, 20)];
            csr_ren    = 1'($urandom_range(0, 1));
            csr_wen    = ($urandom_range(0, 2) == 0);
            csr_wdata  = $urandom;
            trap_en    = ($urandom_range(0, 9) == 0);
            exception_returned = ($urandom_range(0, 9) == 0);
            trap_cause = ($urandom_range(0, 3) == 0) ? $urandom : {1'($urandom_range(0, 1)), 31'($urandom_range(0, 15))};
            trap_pc    = $urandom;
            trap_tval  = $urandom;
            instret_pulse = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                irq_ext = 1'($urandom_range(0, 1)); irq_timer = 1'($urandom_range(0, 1)); irq_soft = 1'($urandom_range(0, 1));
            end
            #1;
            n_checks++;
            if (csr_rdata !== exp_rdata(csr_rwaddr)) begin
                n_fail++; $display("FAIL rand_rdata addr=%h got %h exp %h", csr_rwaddr, csr_rdata, exp_rdata(csr_rwaddr));
            end
            n_checks++;
            if (illegal_csr !== exp_illegal(csr_ren, csr_wen, csr_rwaddr)) begin
                n_fail++; $display("FAIL rand_illegal addr=%h got %b exp %b", csr_rwaddr, illegal_csr, exp_illegal(csr_ren, csr_wen, csr_rwaddr));
            end
            n_checks++;
            if (trap_vector !== exp_vector(trap_cause)) begin
                n_fail++; $display("FAIL rand_vector cause=%h got %h exp %h", trap_cause, trap_vector, exp_vector(trap_cause));
            end
            n_checks++;
            if (interrupt_pending !== |(m_ip & m_ie) || interrupt_req !== (m_mie && |(m_ip & m_ie))) begin
                n_fail++; $display("FAIL rand_irq req=%b pend=%b exp %b/%b", interrupt_req, interrupt_pending, m_mie && |(m_ip & m_ie), |(m_ip & m_ie));
            end
            n_checks++;
            if (csr_mepc !== m_epc) begin n_fail++; $display("FAIL rand_mepc got %h exp %h", csr_mepc, m_epc); end
            step();
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scratch_and_readonly();
        test_interrupts();
        test_trap_vector();
        test_precedence();
        test_counters();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
